// File: rtl/key_lock_ctrl.sv
// Password front end for the gated memory: collects key digits, checks them against a
// stored password, drives the unlock gate and enforces a timed lockout after repeated misses.
module key_lock_ctrl #(
   parameter int                      KEY_W       = 4,
   parameter int                      PW_LEN      = 4,
   parameter logic [KEY_W*PW_LEN-1:0] PASSWORD    = 16'h1947,
   parameter int                      MAX_FAIL    = 3,
   parameter int                      LOCKOUT_CYC = 1000,
   parameter int                      UNLOCK_CYC  = 5000
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [KEY_W-1:0]                  key_in,
   input  logic                              en_key,
   input  logic                              lock_req,
   input  logic                              mem_access,
   output logic                              o_unlock,
   output logic                              o_locked_out,
   output logic [$clog2(MAX_FAIL+1)-1:0]     o_fail_cnt,
   output logic [$clog2(PW_LEN+1)-1:0]       o_digit_cnt
);

   localparam int ENTRY_W = KEY_W * PW_LEN;
   localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
   localparam int DIG_W   = $clog2(PW_LEN + 1);
   localparam int TMR_MAX = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [DIG_W-1:0]  DIG_LAST     = DIG_W'(PW_LEN - 1);
   localparam logic [FAIL_W-1:0] FAIL_MAX     = FAIL_W'(MAX_FAIL);
   localparam logic [TMR_W-1:0]  UNLOCK_LOAD  = TMR_W'(UNLOCK_CYC - 1);
   localparam logic [TMR_W-1:0]  LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYC - 1);

   typedef enum logic [1:0] {
      LOCKED,
      CHECK,
      UNLOCKED,
      LOCKOUT
   } state_t;

   state_t              state;
   logic [ENTRY_W-1:0]  entry;
   logic [TMR_W-1:0]    timer;
   logic [FAIL_W-1:0]   fail_next;

   // Miss counter saturates so a stray extra miss can never wrap it back to zero.
   assign fail_next = (o_fail_cnt == FAIL_MAX) ? FAIL_MAX : o_fail_cnt + FAIL_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= LOCKED;
         entry        <= '0;
         timer        <= '0;
         o_unlock     <= 1'b0;
         o_locked_out <= 1'b0;
         o_fail_cnt   <= '0;
         o_digit_cnt  <= '0;
      end else begin
         case (state)
            LOCKED: begin
               if (lock_req) begin
                  entry       <= '0;
                  o_digit_cnt <= '0;
               end else if (en_key) begin
                  entry       <= (entry << KEY_W) | ENTRY_W'(key_in);
                  o_digit_cnt <= o_digit_cnt + DIG_W'(1);
                  if (o_digit_cnt == DIG_LAST) begin
                     state <= CHECK;
                  end
               end
            end

            CHECK: begin
               entry       <= '0;
               o_digit_cnt <= '0;
               if (entry == PASSWORD) begin
                  state      <= UNLOCKED;
                  o_unlock   <= 1'b1;
                  o_fail_cnt <= '0;
                  timer      <= UNLOCK_LOAD;
               end else begin
                  o_fail_cnt <= fail_next;
                  if (fail_next == FAIL_MAX) begin
                     state        <= LOCKOUT;
                     o_locked_out <= 1'b1;
                     timer        <= LOCKOUT_LOAD;
                  end else begin
                     state <= LOCKED;
                  end
               end
            end

            // Explicit relock wins, then activity, then idle expiry.
            UNLOCKED: begin
               if (lock_req) begin
                  state    <= LOCKED;
                  o_unlock <= 1'b0;
               end else if (mem_access) begin
                  timer <= UNLOCK_LOAD;
               end else if (timer == '0) begin
                  state    <= LOCKED;
                  o_unlock <= 1'b0;
               end else begin
                  timer <= timer - TMR_W'(1);
               end
            end

            LOCKOUT: begin
               if (timer == '0) begin
                  state        <= LOCKED;
                  o_locked_out <= 1'b0;
                  o_fail_cnt   <= '0;
               end else begin
                  timer <= timer - TMR_W'(1);
               end
            end

            default: begin
               state        <= LOCKED;
               entry        <= '0;
               o_unlock     <= 1'b0;
               o_locked_out <= 1'b0;
               o_digit_cnt  <= '0;
            end
         endcase
      end
   end

endmodule
